// File: rtl/rr_slot_sched.sv
// Time-slice round-robin scheduler: grants one requester at a time for a slot of
// at most QUANTUM cycles and tracks the slot with an internal up-counter.
module rr_slot_sched #(
    parameter int NREQ    = 4,
    parameter int QUANTUM = 12,
    localparam int IDW    = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = ($clog2(QUANTUM) > 1) ? $clog2(QUANTUM) : 1
) (
    input  logic            clk,
    input  logic            sreset,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grant_id,
    output logic            o_busy,
    output logic [CW-1:0]   o_slot_cnt,
    output logic            o_slot_last
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CW-1:0]  CNT_LAST = CW'(QUANTUM - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NREQ - 1);

    state_t         state, state_n;
    logic [IDW-1:0] ptr, ptr_n;
    logic [IDW-1:0] gid, gid_n;
    logic [CW-1:0]  cnt, cnt_n;
    logic [NREQ-1:0] grant_vec;
    logic [IDW:0]   pick_all, pick_oth;

    // Returns {found, id}: first requesting id after 'from', wrapping modulo NREQ,
    // with 'from' itself visited last.
    function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] req,
                                             input logic [IDW-1:0]  from);
        logic [IDW-1:0] idx;
        logic           found;
        logic [IDW-1:0] win;
        idx   = from;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (idx == ID_LAST) ? '0 : idx + IDW'(1);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    always_comb begin
        grant_vec = '0;
        for (int k = 0; k < NREQ; k++) begin
            grant_vec[k] = (state == GRANT) && (gid == IDW'(k));
        end
    end

    // In GRANT ptr always equals gid, so searching from ptr starts at g+1.
    assign pick_all = rr_pick(i_req, ptr);
    assign pick_oth = rr_pick(i_req & ~grant_vec, ptr);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        gid_n   = gid;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (pick_all[IDW]) begin
                    state_n = GRANT;
                    ptr_n   = pick_all[IDW-1:0];
                    gid_n   = pick_all[IDW-1:0];
                    cnt_n   = '0;
                end
            end
            GRANT: begin
                if (!i_req[gid]) begin
                    if (pick_oth[IDW]) begin
                        ptr_n = pick_oth[IDW-1:0];
                        gid_n = pick_oth[IDW-1:0];
                        cnt_n = '0;
                    end else begin
                        state_n = IDLE;
                        gid_n   = '0;
                        cnt_n   = '0;
                    end
                end else if (cnt == CNT_LAST) begin
                    // Current holder still requests, so a winner always exists.
                    ptr_n = pick_all[IDW-1:0];
                    gid_n = pick_all[IDW-1:0];
                    cnt_n = '0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                gid_n   = '0;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state <= IDLE;
            ptr   <= ID_LAST;
            gid   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            gid   <= gid_n;
            cnt   <= cnt_n;
        end
    end

    assign o_grant     = grant_vec;
    assign o_grant_id  = gid;
    assign o_busy      = (state == GRANT);
    assign o_slot_cnt  = cnt;
    assign o_slot_last = (state == GRANT) && (cnt == CNT_LAST);

endmodule

// File: tb/tb_rr_slot_sched.sv
// Bench for rr_slot_sched: vector table, directed slot sequences and random
// requests checked every cycle against a behavioural scheduler model.
module tb_rr_slot_sched;

    localparam int NREQ    = 4;
    localparam int QUANTUM = 12;

    logic       clk = 1'b0;
    logic       sreset;
    logic [3:0] i_req;
    logic [3:0] o_grant;
    logic [1:0] o_grant_id;
    logic       o_busy;
    logic [3:0] o_slot_cnt;
    logic       o_slot_last;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: whether someone holds the resource, who, how many cycles
    // of the slot have elapsed, and the last id granted.
    int m_busy, m_g, m_cnt, m_ptr;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] id;
        logic       busy;
        logic [3:0] cnt;
        logic       last;
    } vec_t;

    vec_t tbl[10];

    rr_slot_sched #(.NREQ(NREQ), .QUANTUM(QUANTUM)) dut (
        .clk         (clk),
        .sreset      (sreset),
        .i_req       (i_req),
        .o_grant     (o_grant),
        .o_grant_id  (o_grant_id),
        .o_busy      (o_busy),
        .o_slot_cnt  (o_slot_cnt),
        .o_slot_last (o_slot_last)
    );

    always #5 clk = ~clk;

    function automatic int rr_search(input logic [3:0] req, input int from, input int span);
        for (int k = 1; k <= span; k++) begin
            if (req[(from + k) % NREQ]) return (from + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_step(input logic rst, input logic [3:0] req);
        int w;
        if (rst) begin
            m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = NREQ - 1;
        end else begin
            if (m_busy == 0) w = rr_search(req, m_ptr, NREQ);
            else if (!req[m_g]) w = rr_search(req, m_g, NREQ - 1);
            else if (m_cnt == QUANTUM - 1) w = rr_search(req, m_g, NREQ);
            else w = -2;
            if (w >= 0) begin
                m_busy = 1; m_g = w; m_ptr = w; m_cnt = 0;
            end else if (w == -1) begin
                m_busy = 0; m_g = 0; m_cnt = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    endtask

    function automatic logic [11:0] model_outs();
        logic [3:0] g;
        g = (m_busy != 0) ? 4'(1 << m_g) : 4'b0000;
        return {g, 2'(m_g), m_busy[0], 4'(m_cnt), (m_busy != 0) && (m_cnt == QUANTUM - 1)};
    endfunction

    function automatic logic [11:0] dut_outs();
        return {o_grant, o_grant_id, o_busy, o_slot_cnt, o_slot_last};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [3:0] req);
        sreset = rst;
        i_req  = req;
        @(posedge clk);
        model_step(rst, req);
        #1;
        check("model", 32'(dut_outs()), 32'(model_outs()));
    endtask

    initial begin
        logic [3:0] r;
        sreset = 1'b1;
        i_req  = 4'b0000;

        tbl[0] = '{1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0};
        tbl[1] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4'd0, 1'b0};
        tbl[2] = '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 4'd1, 1'b0};
        tbl[3] = '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 4'd0, 1'b0};
        tbl[4] = '{1'b0, 4'b0101, 4'b0100, 2'd2, 1'b1, 4'd1, 1'b0};
        tbl[5] = '{1'b0, 4'b0001, 4'b0001, 2'd0, 1'b1, 4'd0, 1'b0};
        tbl[6] = '{1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'd0, 1'b0};
        tbl[7] = '{1'b0, 4'b1000, 4'b1000, 2'd3, 1'b1, 4'd0, 1'b0};
        tbl[8] = '{1'b0, 4'b1001, 4'b1000, 2'd3, 1'b1, 4'd1, 1'b0};
        tbl[9] = '{1'b0, 4'b0011, 4'b0001, 2'd0, 1'b1, 4'd0, 1'b0};

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].req);
            check($sformatf("tbl%0d", i), 32'(dut_outs()),
                  32'({tbl[i].grant, tbl[i].id, tbl[i].busy, tbl[i].cnt, tbl[i].last}));
        end

        // Lone requester: full slot then immediate re-grant.
        step(1'b1, 4'b0001);
        for (int i = 0; i < QUANTUM; i++) step(1'b0, 4'b0001);
        check("lone_last", {o_slot_last, o_slot_cnt}, {1'b1, 4'd11});
        step(1'b0, 4'b0001);
        check("lone_regrant", {o_grant, o_slot_cnt, o_slot_last}, {4'b0001, 4'd0, 1'b0});

        // All requesting: 0,1,2,3,0 with 12 cycles each, no busy gap.
        step(1'b1, 4'b1111);
        for (int c = 0; c < 5 * QUANTUM; c++) begin
            step(1'b0, 4'b1111);
            check("rotate", {o_busy, o_grant_id, o_slot_cnt},
                  {1'b1, 2'((c / QUANTUM) % NREQ), 4'(c % QUANTUM)});
        end

        // Early release with another requester pending, then with none.
        step(1'b1, 4'b0000);
        step(1'b0, 4'b0010);
        for (int i = 0; i < 4; i++) step(1'b0, 4'b0010);
        check("rel_at4", {o_grant_id, o_slot_cnt}, {2'd1, 4'd4});
        step(1'b0, 4'b0100);
        check("rel_handover", {o_busy, o_grant_id, o_slot_cnt}, {1'b1, 2'd2, 4'd0});
        step(1'b1, 4'b0000);
        for (int i = 0; i < 5; i++) step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        check("rel_idle", {o_busy, o_grant}, {1'b0, 4'b0000});

        // Release coinciding with the last slot cycle.
        step(1'b1, 4'b0000);
        for (int i = 0; i < QUANTUM; i++) step(1'b0, 4'b0100);
        check("drop_last_pre", {o_slot_last, o_grant_id}, {1'b1, 2'd2});
        step(1'b0, 4'b0000);
        check("drop_last_idle", {o_busy, o_grant, o_slot_cnt}, {1'b0, 4'b0000, 4'd0});

        // Reset mid-slot while id 2 holds the resource.
        step(1'b1, 4'b1111);
        for (int c = 0; c < 2 * QUANTUM + 8; c++) step(1'b0, 4'b1111);
        check("rst_pre", {o_grant_id, o_slot_cnt}, {2'd2, 4'd7});
        step(1'b1, 4'b1111);
        check("rst_mid", 32'(dut_outs()), 32'(12'h000));
        step(1'b0, 4'b1111);
        check("rst_after", {o_grant, o_grant_id, o_busy}, {4'b0001, 2'd0, 1'b1});

        // Random requests with persistence and occasional resets.
        r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) r = 4'($urandom);
            step(($urandom_range(0, 99) == 0), r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_slot_sched.md
# rr_slot_sched

Time-slice round-robin scheduler that shares one counter-driven resource (an `upcount`-style datapath) among `NREQ` requesters. It grants one requester at a time for a slot of at most `QUANTUM` cycles and tracks the slot with an internal up-counter. It exposes `o_slot_last` with the same semantics as the counters' `o_last`. It sits between the requesting blocks and the shared resource; the granted id drives the resource's input mux.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..16.
- `QUANTUM`, default 12: maximum slot length in cycles; legal range ≥1.
- Derived widths:
  - `IDW = max(1, $clog2(NREQ))`.
  - `CW = max(1, $clog2(QUANTUM))`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `sreset` in 1: synchronous, active-high reset.
- `i_req` in NREQ: level request per requester; bit k is held high while requester k wants the resource.
- `o_grant` out NREQ: one-hot grant, or all-zero when idle.
- `o_grant_id` out IDW: binary index of the granted requester; 0 when idle.
- `o_busy` out 1: high while any grant is active.
- `o_slot_cnt` out CW: cycles elapsed in the current slot, from 0 to QUANTUM-1.
- `o_slot_last` out 1: high in the final cycle of a slot (`o_busy && o_slot_cnt == QUANTUM-1`).

## Operation
- State: FSM {IDLE, GRANT}, round-robin pointer `ptr` (IDW bits) holding the last granted id, and slot counter `cnt`.
- Reset values: state=IDLE, `ptr`=NREQ-1 so that requester 0 has first priority, `o_grant`=0, `o_grant_id`=0, `o_busy`=0, `o_slot_cnt`=0, `o_slot_last`=0.
- Round-robin pick: search ids `ptr+1, ptr+2, …` with modulo-NREQ wrap. The first id with `i_req` high wins. Every grant sets `ptr` to the winner and `cnt` to 0.
- IDLE:
  - If `i_req` is nonzero, go to GRANT with the pick.
  - Otherwise stay in IDLE.
- GRANT, with current id g, evaluated at each edge in this priority order:
  1. **Release** (`i_req[g]` low): re-pick excluding g.
     - If another requester wins, grant it back-to-back with no idle cycle.
     - Otherwise go to IDLE and clear the outputs.
  2. **Expiry** (`cnt == QUANTUM-1`, requester still requesting): re-pick over all ids starting at g+1, with g last.
     - If g is the only requester, g is re-granted and `cnt` returns to 0.
  3. **Otherwise**: `cnt` increments by 1. No wrap is possible because expiry handles QUANTUM-1.
- Release and expiry in the same cycle are treated as a release.
- `QUANTUM=1`: every granted cycle is a last cycle; arbitration repeats every cycle.
- `o_grant` is always one-hot or zero and always matches `o_grant_id` and `o_busy`.
- Requests that arrive for non-granted ids never affect the current slot; they are only considered at the next arbitration point.

## Timing
- All outputs are registered, or decoded only from registers. There is no combinational path from `i_req` to any output.
- Request-to-grant latency:
  - From IDLE: 1 cycle. `i_req` high at edge N gives `o_grant` valid after edge N.
- Slot length: exactly QUANTUM cycles with `o_busy` high per grant, unless released early.
- `o_slot_last` is high for exactly one cycle per full slot.
- Handover:
  - On expiry or release with another requester pending, the new grant appears the cycle after the last cycle of the old grant; `o_busy` stays high with no gap.
  - On release with no requester pending, `o_busy` falls 1 cycle after `i_req[g]` is seen low.
- `sreset` mid-slot: after the edge where it is sampled, all outputs and `ptr` take their reset values. `sreset` overrides all requests in that cycle.

## Test plan
- Reset with all `i_req` high → after the `sreset` edge: `o_grant`=0, `o_busy`=0, `o_slot_cnt`=0. After `sreset` deasserts: `o_grant`=4'b0001 one cycle later.
- Only `i_req[0]` held, QUANTUM=12:
  - `o_slot_last` rises with `o_slot_cnt`=11 on the 12th granted cycle.
  - The next cycle shows `o_grant`=0001 again with `o_slot_cnt`=0.
- `i_req`=4'b1111 held → grant sequence 0,1,2,3,0, each exactly 12 cycles, with `o_busy` continuously high.
- Requester 1 granted, `i_req[1]` dropped at `o_slot_cnt`=4 while `i_req[2]` is high → the next cycle shows `o_grant_id`=2 and `o_slot_cnt`=0. The same drop with no other requests → `o_busy`=0 the next cycle.
- `i_req[g]` dropped in the same cycle as `o_slot_last`, with only g previously requesting → IDLE next cycle, g not re-granted.
- `sreset` pulsed at `o_slot_cnt`=7 while id 2 is granted and `i_req`=1111 → outputs zero the next cycle; the next grant after release of reset is id 0.
